// File: rtl/apb_frame_sequencer_if.sv
// Bundle of frame, APB master, UART TX and error-pulse signals around apb_frame_sequencer.
// master = sequencer side, slave = environment (frame assembler, APB slave, UART TX).
interface apb_frame_sequencer_if;
  logic [55:0] frame_in;
  logic        frame_vld;
  logic        busy;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        err_illegal;
  logic        err_overrun;
  logic        err_slv;
  logic        err_timeout;

  modport master (
    input  frame_in, frame_vld, prdata, pready, pslverr, tx_rdy,
    output busy, psel, penable, pwrite, paddr, pwdata, tx_data, tx_vld,
           err_illegal, err_overrun, err_slv, err_timeout
  );

  modport slave (
    output frame_in, frame_vld, prdata, pready, pslverr, tx_rdy,
    input  busy, psel, penable, pwrite, paddr, pwdata, tx_data, tx_vld,
           err_illegal, err_overrun, err_slv, err_timeout
  );
endinterface

// File: rtl/apb_frame_sequencer.sv
// Frame-to-APB command sequencer with 5-byte read response streaming to the UART TX.
// Optional ACCESS-phase timeout enabled by defining SEQ_TIMEOUT_EN.
module apb_frame_sequencer #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  apb_frame_sequencer_if.master bus
);

  // state  | meaning
  // IDLE   | waiting for a frame
  // SETUP  | APB setup phase (psel=1, penable=0)
  // ACCESS | APB access phase, waiting for pready
  // RESP   | streaming the 5-byte read response
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         rdbuf_q, rdbuf_d;
  logic [2:0]          idx_q, idx_d;
  logic                err_ill_q, err_ill_d;
  logic                err_ovr_q, err_ovr_d;
  logic                err_slv_q, err_slv_d;
  logic                err_tmo_q, err_tmo_d;
  logic [2:0]          cmd;
  logic                cmd_legal;
  logic [7:0]          tx_byte;
  logic                unused_frame_bits;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

  assign cmd               = bus.frame_in[50:48];
  assign cmd_legal         = (cmd == 3'd2) || (cmd == 3'd3);
  assign unused_frame_bits = ^bus.frame_in[55:51];

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    rdbuf_d   = rdbuf_q;
    idx_d     = idx_q;
    err_ill_d = 1'b0;
    err_ovr_d = bus.frame_vld && (state_q != IDLE);
    err_slv_d = 1'b0;
    err_tmo_d = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.frame_vld) begin
          if (cmd_legal) begin
            state_d  = SETUP;
            paddr_d  = bus.frame_in[47:32];
            pwrite_d = (cmd == 3'd2);
            // read frames carry no data, so the last write data is kept
            if (cmd == 3'd2) pwdata_d = bus.frame_in[31:0];
          end else begin
            err_ill_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ACCESS: begin
        if (bus.pready) begin
          err_slv_d = bus.pslverr;
          if (pwrite_q) begin
            state_d = IDLE;
          end else begin
            rdbuf_d = bus.prdata;
            idx_d   = 3'd0;
            state_d = RESP;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          if (pwrite_q) begin
            state_d = IDLE;
          end else begin
            rdbuf_d = 32'hFFFF_FFFF;
            idx_d   = 3'd0;
            state_d = RESP;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.tx_rdy) begin
          if (idx_q == 3'd4) begin
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rdbuf_q   <= '0;
      idx_q     <= '0;
      err_ill_q <= 1'b0;
      err_ovr_q <= 1'b0;
      err_slv_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      rdbuf_q   <= rdbuf_d;
      idx_q     <= idx_d;
      err_ill_q <= err_ill_d;
      err_ovr_q <= err_ovr_d;
      err_slv_q <= err_slv_d;
      err_tmo_q <= err_tmo_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    tx_byte = 8'h00;
    if (state_q == RESP) begin
      case (idx_q)
        3'd0:    tx_byte = 8'h04;
        3'd1:    tx_byte = rdbuf_q[31:24];
        3'd2:    tx_byte = rdbuf_q[23:16];
        3'd3:    tx_byte = rdbuf_q[15:8];
        3'd4:    tx_byte = rdbuf_q[7:0];
        default: tx_byte = 8'h00;
      endcase
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable     = (state_q == ACCESS);
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.tx_vld      = (state_q == RESP);
  assign bus.tx_data     = tx_byte;
  assign bus.err_illegal = err_ill_q;
  assign bus.err_overrun = err_ovr_q;
  assign bus.err_slv     = err_slv_q;
`ifdef SEQ_TIMEOUT_EN
  assign bus.err_timeout = err_tmo_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

endmodule
